// File: rtl/adc_sample_conditioner_if.sv
// adc_sample_conditioner_if: raw sample stream in, conditioned sample and trigger out.
interface adc_sample_conditioner_if #(parameter int DATA_W = 12);
   logic [DATA_W-1:0] adc_din;
   logic              adc_din_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              trig_out;
   modport master (output adc_din, adc_din_valid, input out_data, out_valid, trig_out);
   modport slave  (input adc_din, adc_din_valid, output out_data, out_valid, trig_out);
endinterface

// File: rtl/adc_sample_conditioner.sv
// adc_sample_conditioner: offset/saturate, boxcar decimate, hysteresis trigger and clip statistics.
module adc_sample_conditioner #(
   parameter int DATA_W       = 12,
   parameter int MAX_DEC_LOG2 = 7
) (
   input  logic                    clk_high,
   input  logic                    rst_n,
   adc_sample_conditioner_if.slave bus,
   input  logic                    cfg_enable,
   input  logic                    cfg_load,
   input  logic signed [DATA_W:0]  cfg_offset,
   input  logic [2:0]              cfg_dec_log2,
   input  logic [DATA_W-1:0]       cfg_trig_level,
   input  logic [7:0]              cfg_trig_hyst,
   input  logic                    ovr_clr,
   output logic                    ovr_flag,
   output logic [15:0]             sat_count
);
   localparam int ACC_W = DATA_W + MAX_DEC_LOG2;
   localparam int CNT_W = MAX_DEC_LOG2;
   typedef enum logic [1:0] {IDLE, WAIT_BELOW, WAIT_ABOVE} state_t;
   state_t state, state_d;
   logic signed [DATA_W:0] off_r;
   logic [2:0]        n_r;
   logic [DATA_W-1:0] lvl_r, c, sat_val, od, lower;
   logic [7:0]        hyst_r;
   logic [DATA_W+1:0] s;
   logic [ACC_W-1:0]  acc, sum;
   logic [CNT_W-1:0]  cnt, last;
   logic neg, over, accept, flush, clip, c_valid, done, ov, trig_d, trig;
   // 14-bit wraparound add is exact: the sum always lies in [-4096, 8190]
   assign s       = {2'b00, bus.adc_din} + {off_r[DATA_W], off_r};
   assign neg     = s[DATA_W+1];
   assign over    = ~neg & s[DATA_W];
   assign sat_val = neg ? '0 : over ? '1 : s[DATA_W-1:0];
   assign accept  = bus.adc_din_valid & cfg_enable & ~cfg_load;
   assign flush   = ~cfg_enable | cfg_load;
   assign clip    = accept & (neg | over);
   assign sum     = acc + ACC_W'(c);
   assign last    = CNT_W'((32'd1 << n_r) - 32'd1);
   assign done    = c_valid & (cnt == last);
   assign lower   = (lvl_r > DATA_W'(hyst_r)) ? lvl_r - DATA_W'(hyst_r) : '0;
   always_ff @(posedge clk_high or negedge rst_n)
      if (!rst_n) begin
         off_r  <= '0;
         n_r    <= '0;
         lvl_r  <= {1'b1, {(DATA_W-1){1'b0}}};
         hyst_r <= 8'd16;
      end else if (cfg_load) begin
         off_r  <= cfg_offset;
         n_r    <= ({1'b0, cfg_dec_log2} > 4'(MAX_DEC_LOG2)) ? 3'(MAX_DEC_LOG2) : cfg_dec_log2;
         lvl_r  <= cfg_trig_level;
         hyst_r <= cfg_trig_hyst;
      end
   // a clip coinciding with ovr_clr restarts the count at one
   always_ff @(posedge clk_high or negedge rst_n)
      if (!rst_n) begin
         ovr_flag  <= 1'b0;
         sat_count <= '0;
      end else if (clip) begin
         ovr_flag  <= 1'b1;
         sat_count <= ovr_clr ? 16'd1 : sat_count + {15'd0, ~&sat_count};
      end else if (ovr_clr) begin
         ovr_flag  <= 1'b0;
         sat_count <= '0;
      end
   always_ff @(posedge clk_high or negedge rst_n)
      if (!rst_n) begin
         c       <= '0;
         c_valid <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         ov      <= 1'b0;
         od      <= '0;
      end else if (flush) begin
         c_valid <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         ov      <= 1'b0;
      end else begin
         c_valid <= accept;
         if (accept) c <= sat_val;
         ov <= done;
         if (c_valid) begin
            acc <= done ? '0 : sum;
            cnt <= done ? '0 : cnt + 1'b1;
         end
         if (done) od <= DATA_W'(sum >> n_r);
      end
   always_ff @(posedge clk_high or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         trig  <= 1'b0;
      end else begin
         state <= state_d;
         trig  <= trig_d;
      end
   always_comb begin
      state_d = state;
      trig_d  = 1'b0;
      if (!cfg_enable) state_d = IDLE;
      else if (cfg_load || state == IDLE) state_d = WAIT_BELOW;
      else if (ov && state == WAIT_BELOW && od <= lower) state_d = WAIT_ABOVE;
      else if (ov && state == WAIT_ABOVE && od >= lvl_r) begin
         state_d = WAIT_BELOW;
         trig_d  = 1'b1;
      end
   end
   assign bus.out_data  = od;
   assign bus.out_valid = ov;
   assign bus.trig_out  = trig;
endmodule

// File: tb/tb_adc_sample_conditioner.sv
// tb_adc_sample_conditioner: directed test-plan cases plus random traffic against a block-level model.
module tb_adc_sample_conditioner;
   logic clk_high = 0, rst_n = 1, cfg_enable = 0, cfg_load = 0, ovr_clr = 0, ovr_flag;
   logic signed [12:0] cfg_offset = 0;
   logic [2:0]  cfg_dec_log2 = 0;
   logic [11:0] cfg_trig_level = 12'd2048;
   logic [7:0]  cfg_trig_hyst = 8'd16;
   logic [15:0] sat_count;
   int errors = 0, checks = 0, n_out = 0, n_trig = 0, last_out = 0, base = 0;
   // reference model state: config, pending conditioned sample, open block, expected outputs
   int m_off, m_n, m_lvl, m_hyst, pend_c, exp_data, exp_sat;
   bit pend_v, exp_ov, exp_trig, exp_ovr, idle, armed;
   int blk[$];
   adc_sample_conditioner_if #(.DATA_W(12)) bus();
   adc_sample_conditioner dut (
      .clk_high(clk_high), .rst_n(rst_n), .bus(bus),
      .cfg_enable(cfg_enable), .cfg_load(cfg_load), .cfg_offset(cfg_offset),
      .cfg_dec_log2(cfg_dec_log2), .cfg_trig_level(cfg_trig_level), .cfg_trig_hyst(cfg_trig_hyst),
      .ovr_clr(ovr_clr), .ovr_flag(ovr_flag), .sat_count(sat_count));
   always #5 clk_high = ~clk_high;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic m_reset();
      m_off = 0; m_n = 0; m_lvl = 2048; m_hyst = 16;
      pend_v = 0; pend_c = 0; blk.delete();
      exp_ov = 0; exp_data = 0; exp_trig = 0; exp_ovr = 0; exp_sat = 0;
      idle = 1; armed = 0;
   endtask
   // advance the model by one clock edge using the inputs currently driven
   task automatic model_edge();
      bit en = cfg_enable, ld = cfg_load, acc, clip = 0, t_next = 0, ov_next = 0;
      int lo = m_lvl - m_hyst, s, c = 0, sum = 0;
      if (lo < 0) lo = 0;
      if (!en) begin idle = 1; armed = 0; end
      else if (ld) begin idle = 0; armed = 0; end
      else if (idle) idle = 0;
      else if (exp_ov) begin
         if (!armed && exp_data <= lo) armed = 1;
         else if (armed && exp_data >= m_lvl) begin armed = 0; t_next = 1; end
      end
      if (!en || ld) blk.delete();
      else if (pend_v) begin
         blk.push_back(pend_c);
         if (blk.size() == (1 << m_n)) begin
            foreach (blk[i]) sum += blk[i];
            exp_data = sum >> m_n;
            ov_next = 1;
            blk.delete();
         end
      end
      acc = bus.adc_din_valid && en && !ld;
      if (acc) begin
         s = int'(bus.adc_din) + m_off;
         clip = (s < 0) || (s > 4095);
         c = (s < 0) ? 0 : (s > 4095) ? 4095 : s;
      end
      pend_v = acc; pend_c = c;
      if (clip) begin
         exp_ovr = 1;
         exp_sat = ovr_clr ? 1 : (exp_sat == 65535 ? 65535 : exp_sat + 1);
      end else if (ovr_clr) begin
         exp_ovr = 0; exp_sat = 0;
      end
      if (ld) begin
         m_off = cfg_offset; m_n = int'(cfg_dec_log2);
         m_lvl = int'(cfg_trig_level); m_hyst = int'(cfg_trig_hyst);
      end
      exp_ov = ov_next; exp_trig = t_next;
   endtask
   task automatic tick();
      model_edge();
      @(posedge clk_high);
      @(negedge clk_high);
      check("out_valid", bus.out_valid, exp_ov);
      check("out_data", bus.out_data, exp_data);
      check("trig_out", bus.trig_out, exp_trig);
      check("ovr_flag", ovr_flag, exp_ovr);
      check("sat_count", sat_count, exp_sat);
      if (bus.out_valid) begin n_out++; last_out = bus.out_data; end
      if (bus.trig_out) n_trig++;
      bus.adc_din_valid = 0; cfg_load = 0; ovr_clr = 0;
   endtask
   task automatic load_cfg(int off, int n, int lvl, int hyst);
      cfg_offset = 13'(off); cfg_dec_log2 = 3'(n);
      cfg_trig_level = 12'(lvl); cfg_trig_hyst = 8'(hyst); cfg_load = 1;
      tick();
   endtask
   task automatic sample(int d);
      bus.adc_din = 12'(d); bus.adc_din_valid = 1;
      tick(); tick();
   endtask
   initial begin
      int trig_seq[6] = '{2100, 2040, 2031, 2050, 2040, 2060};
      int trig_exp[6] = '{0, 0, 0, 1, 1, 1};
      bus.adc_din = 0; bus.adc_din_valid = 0;
      #1 rst_n = 0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_trig", bus.trig_out, 0);
      check("rst_ovr", ovr_flag, 0);
      check("rst_sat", sat_count, 0);
      m_reset();
      repeat (2) @(negedge clk_high);
      rst_n = 1;
      tick();
      cfg_enable = 1;
      load_cfg(100, 0, 2048, 16);
      sample(1000);
      check("n0_offset", last_out, 1100);
      sample(4050);
      check("n0_sat_hi", last_out, 4095);
      check("ovr_after_hi", ovr_flag, 1);
      check("sat_after_hi", sat_count, 1);
      load_cfg(-200, 0, 2048, 16);
      sample(150);
      check("n0_sat_lo", last_out, 0);
      check("sat_after_lo", sat_count, 2);
      bus.adc_din = 12'd150; bus.adc_din_valid = 1; ovr_clr = 1;
      tick();
      check("clr_vs_clip_sat", sat_count, 1);
      check("clr_vs_clip_ovr", ovr_flag, 1);
      for (int i = 0; i < 70000; i++) begin
         bus.adc_din = 0; bus.adc_din_valid = 1;
         tick();
      end
      check("sat_hold", sat_count, 16'hFFFF);
      ovr_clr = 1;
      tick();
      check("clr_sat", sat_count, 0);
      check("clr_ovr", ovr_flag, 0);
      load_cfg(0, 2, 2048, 16);
      base = n_out;
      sample(10); sample(11); sample(12);
      check("n2_partial", n_out, base);
      sample(14);
      check("n2_count", n_out, base + 1);
      check("n2_mean", last_out, 11);
      load_cfg(0, 3, 2048, 16);
      repeat (5) sample(100);
      load_cfg(0, 3, 2048, 16);
      base = n_out;
      repeat (8) sample(800);
      check("n3_discard_count", n_out, base + 1);
      check("n3_mean", last_out, 800);
      load_cfg(0, 7, 2048, 16);
      base = n_out;
      repeat (128) sample(4095);
      check("n7_count", n_out, base + 1);
      check("n7_full_scale", last_out, 4095);
      load_cfg(0, 0, 2048, 16);
      base = n_trig;
      foreach (trig_seq[i]) begin
         sample(trig_seq[i]);
         tick();
         check($sformatf("trig_after_%0d", trig_seq[i]), n_trig - base, trig_exp[i]);
      end
      load_cfg(-10, 2, 2048, 16);
      sample(5); sample(500);
      base = n_out;
      cfg_enable = 0;
      repeat (3) tick();
      check("dis_no_out", n_out, base);
      check("dis_ovr_hold", ovr_flag, 1);
      cfg_enable = 1;
      tick();
      sample(100); sample(200); sample(300); sample(400);
      check("reen_count", n_out, base + 1);
      check("reen_mean", last_out, 240);
      for (int i = 0; i < 3000; i++) begin
         cfg_enable = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 99) == 0) begin
            cfg_offset = 13'($urandom_range(0, 8191)); cfg_dec_log2 = 3'($urandom_range(0, 4));
            cfg_trig_level = 12'($urandom); cfg_trig_hyst = 8'($urandom); cfg_load = 1;
         end
         bus.adc_din = 12'($urandom); bus.adc_din_valid = 1'($urandom_range(0, 1));
         ovr_clr = ($urandom_range(0, 63) == 0);
         tick();
      end
      cfg_enable = 1;
      load_cfg(-300, 2, 2048, 16);
      sample(7); sample(9);
      rst_n = 0;
      #1;
      check("arst_out_data", bus.out_data, 0);
      check("arst_ovr", ovr_flag, 0);
      check("arst_sat", sat_count, 0);
      m_reset();
      @(negedge clk_high);
      rst_n = 1;
      base = n_out;
      repeat (4) sample(40);
      check("post_rst_count", n_out, base + 4);
      check("post_rst_data", last_out, 40);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
